// File: rtl/seq_mult_if.sv
// Handshake and operand/result bundle for the sequential shift-add multiplier.
interface seq_mult_if #(parameter int WIDTH = 16);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 sgn;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;
    logic                 done;

    modport master (output start, a, b, sgn, input product, busy, done);
    modport slave  (input start, a, b, sgn, output product, busy, done);
endinterface

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier, signed or unsigned operands.
// Multiplies magnitudes and applies the sign once at the end.
module seq_mult #(
    parameter int WIDTH = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    seq_mult_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t             state, state_nxt;
    logic [2*WIDTH-1:0] ma;
    logic [WIDTH-1:0]   mb;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] product_q;
    logic               neg;

    // One extra bit keeps |-2^(WIDTH-1)| exact.
    logic               a_neg, b_neg;
    logic [WIDTH:0]     a_ext, a_mag;
    logic [WIDTH-1:0]   b_mag;

    assign a_neg = bus.sgn & bus.a[WIDTH-1];
    assign b_neg = bus.sgn & bus.b[WIDTH-1];
    assign a_ext = {a_neg, bus.a};
    assign a_mag = a_neg ? -a_ext : a_ext;
    assign b_mag = b_neg ? -bus.b : bus.b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = CALC;
            CALC:    if (mb == '0)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma        <= '0;
            mb        <= '0;
            acc       <= '0;
            neg       <= 1'b0;
            product_q <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    ma  <= {{(WIDTH-1){1'b0}}, a_mag};
                    mb  <= b_mag;
                    neg <= a_neg ^ b_neg;
                    acc <= '0;
                end
                CALC: if (mb != '0) begin
                    if (mb[0]) acc <= acc + ma;
                    ma <= ma << 1;
                    mb <= mb >> 1;
                end else begin
                    product_q <= neg ? -acc : acc;
                end
                default: ;
            endcase
        end
    end

    assign bus.product = product_q;
    assign bus.busy    = (state == CALC);
    assign bus.done    = (state == DONE);
endmodule
